// File: rtl/snes_pad_responder_pkg.sv
// Shared definitions for the SNES pad serial protocol: button bit positions,
// frame length and the responder state encoding.
package snes_pad_responder_pkg;

  localparam int SNES_BUTTON_BITS = 12;
  localparam int SNES_FRAME_BITS  = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_e;

endpackage

// File: rtl/snes_pad_responder_if.sv
// Pad-side signal bundle: the host (master) drives latch/clock and the button
// state source, the responder (slave) returns serial data and status.
interface snes_pad_responder_if
  import snes_pad_responder_pkg::*;
;
  logic [SNES_BUTTON_BITS-1:0] buttons;
  logic                        snes_latch;
  logic                        snes_clock;
  logic                        snes_data;
  logic                        busy;
  logic [7:0]                  frame_count;

  modport master (
    output buttons, snes_latch, snes_clock,
    input  snes_data, busy, frame_count
  );

  modport slave (
    input  buttons, snes_latch, snes_clock,
    output snes_data, busy, frame_count
  );
endinterface

// File: rtl/snes_pad_responder_sync_edge.sv
// N-stage synchroniser for an asynchronous input, plus a history flop that
// turns the synchronised level into single-cycle rise/fall pulses.
module snes_pad_responder_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[STAGES-1] & r_hist;
endmodule

// File: rtl/snes_pad_responder.sv
// Device end of the SNES pad protocol: filters the host latch, captures the
// buttons and shifts them out active-low on each host clock rise.
module snes_pad_responder
  import snes_pad_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BITS    = SNES_FRAME_BITS,
  parameter int MIN_LATCH   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  snes_pad_responder_if.slave  pad
);
  localparam int CNT_W  = $clog2(NUM_BITS + 1);
  localparam int LCNT_W = $clog2(MIN_LATCH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(NUM_BITS - 1);
  localparam logic [LCNT_W-1:0] LATCH_THR = LCNT_W'(MIN_LATCH - 1);
  localparam logic [LCNT_W-1:0] LATCH_MAX = LCNT_W'(MIN_LATCH);

  logic w_latch_level, w_latch_rise, w_latch_fall;
  logic w_clk_level, w_clk_rise, w_clk_fall;
  logic w_latch_ok;
  logic w_unused;

  snes_state_e         r_state;
  logic [NUM_BITS-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [LCNT_W-1:0]   r_latch_cnt;
  logic                r_data;
  logic                r_busy;
  logic [7:0]          r_frame_cnt;

  snes_pad_responder_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (pad.snes_latch),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  snes_pad_responder_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clock (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (pad.snes_clock),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  assign w_unused = ^{w_latch_rise, w_clk_level, w_clk_fall};

  // Glitch filter: a latch counts only after MIN_LATCH consecutive high cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_latch_cnt <= '0;
    end else if (!w_latch_level) begin
      r_latch_cnt <= '0;
    end else if (r_latch_cnt != LATCH_MAX) begin
      r_latch_cnt <= r_latch_cnt + 1'b1;
    end
  end

  assign w_latch_ok = w_latch_level && (r_latch_cnt >= LATCH_THR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '1;
      r_bit_cnt   <= '0;
      r_data      <= 1'b1;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else if (w_latch_ok) begin
      // An accepted latch wins over everything, including a coincident clock edge.
      r_state   <= ST_LATCH;
      r_shift   <= {{(NUM_BITS-SNES_BUTTON_BITS){1'b1}}, ~pad.buttons};
      r_data    <= ~pad.buttons[BTN_B];
      r_busy    <= 1'b1;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_data <= 1'b1;
          r_busy <= 1'b0;
        end
        ST_LATCH: begin
          if (w_latch_fall) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_clk_rise) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state     <= ST_DONE;
              r_data      <= 1'b0;
              r_busy      <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
              r_shift <= {1'b1, r_shift[NUM_BITS-1:1]};
              r_data  <= r_shift[1];
            end
          end
        end
        ST_DONE: begin
          r_data <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pad.snes_data   = r_data;
  assign pad.busy        = r_busy;
  assign pad.frame_count = r_frame_cnt;
endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: acts as the SNES host, driving
// latch/clock and checking the serial stream, latency and frame counter.
module tb_snes_pad_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_fc;

  snes_pad_responder_if pad_if ();

  snes_pad_responder #(.SYNC_STAGES(2), .NUM_BITS(16), .MIN_LATCH(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .pad     (pad_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_latch(input int high_cycles, input int low_cycles);
    pad_if.snes_latch = 1'b1;
    tick(high_cycles);
    pad_if.snes_latch = 1'b0;
    tick(low_cycles);
  endtask

  task automatic host_frame(input int half, output logic [15:0] word);
    word = '0;
    for (int i = 0; i < 16; i++) begin
      pad_if.snes_clock = 1'b0;
      tick(half);
      word[i] = pad_if.snes_data;
      pad_if.snes_clock = 1'b1;
      tick(half);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    exp_fc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pad_if.snes_latch = ~pad_if.snes_latch;
      pad_if.snes_clock = ~pad_if.snes_clock;
      tick(2);
      checks++;
      if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b0 || pad_if.frame_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got data=%b busy=%b fc=%0d required data=1 busy=0 fc=0",
                 i, pad_if.snes_data, pad_if.busy, pad_if.frame_count);
      end
    end
    pad_if.snes_latch = 1'b0;
    pad_if.snes_clock = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    exp_fc = 0;
    checks++;
    if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got data=%b busy=%b required data=1 busy=0", pad_if.snes_data, pad_if.busy);
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] word;
    pad_if.buttons = 12'h001;
    pad_if.snes_latch = 1'b1;
    tick(3);
    checks++;
    if (pad_if.busy !== 1'b0 || pad_if.snes_data !== 1'b1) begin
      errors++;
      $display("FAIL latch_latency_early: got busy=%b data=%b required busy=0 data=1", pad_if.busy, pad_if.snes_data);
    end
    tick(1);
    checks++;
    if (pad_if.busy !== 1'b1 || pad_if.snes_data !== 1'b0) begin
      errors++;
      $display("FAIL latch_latency: got busy=%b data=%b required busy=1 data=0", pad_if.busy, pad_if.snes_data);
    end
    tick(8);
    pad_if.snes_latch = 1'b0;
    tick(6);
    word = '0;
    pad_if.snes_clock = 1'b0;
    tick(8);
    word[0] = pad_if.snes_data;
    pad_if.snes_clock = 1'b1;
    tick(2);
    checks++;
    if (pad_if.snes_data !== 1'b0) begin
      errors++;
      $display("FAIL clock_latency_early: got data=%b required 0", pad_if.snes_data);
    end
    tick(1);
    checks++;
    if (pad_if.snes_data !== 1'b1) begin
      errors++;
      $display("FAIL clock_latency: got data=%b required 1", pad_if.snes_data);
    end
    tick(5);
    for (int i = 1; i < 16; i++) begin
      pad_if.snes_clock = 1'b0;
      tick(8);
      word[i] = pad_if.snes_data;
      pad_if.snes_clock = 1'b1;
      tick(8);
    end
    exp_fc = exp_fc + 1;
    checks++;
    if (word !== 16'hFFFE) begin
      errors++;
      $display("FAIL full_frame_stream: got %h required %h", word, 16'hFFFE);
    end
    checks++;
    if (pad_if.snes_data !== 1'b0 || pad_if.busy !== 1'b0 || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL full_frame_done: got data=%b busy=%b fc=%0d required data=0 busy=0 fc=%0d",
               pad_if.snes_data, pad_if.busy, pad_if.frame_count, exp_fc);
    end
  endtask

  task automatic test_glitch();
    pad_if.snes_latch = 1'b1;
    tick(1);
    pad_if.snes_latch = 1'b0;
    tick(10);
    checks++;
    if (pad_if.snes_data !== 1'b0 || pad_if.busy !== 1'b0 || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL glitch_done: got data=%b busy=%b fc=%0d required data=0 busy=0 fc=%0d",
               pad_if.snes_data, pad_if.busy, pad_if.frame_count, exp_fc);
    end
    pulse_reset();
    pad_if.snes_latch = 1'b1;
    tick(1);
    pad_if.snes_latch = 1'b0;
    tick(10);
    checks++;
    if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got data=%b busy=%b required data=1 busy=0", pad_if.snes_data, pad_if.busy);
    end
  endtask

  task automatic test_coincident();
    logic [15:0] word;
    pad_if.buttons = 12'h002;
    pad_if.snes_clock = 1'b0;
    tick(6);
    pad_if.snes_latch = 1'b1;
    pad_if.snes_clock = 1'b1;
    tick(12);
    pad_if.snes_latch = 1'b0;
    tick(6);
    checks++;
    if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL coincident_first_bit: got data=%b busy=%b required data=1 busy=1", pad_if.snes_data, pad_if.busy);
    end
    host_frame(6, word);
    exp_fc = exp_fc + 1;
    checks++;
    if (word !== 16'hFFFD || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL coincident_stream: got %h fc=%0d required %h fc=%0d", word, pad_if.frame_count, 16'hFFFD, exp_fc);
    end
  endtask

  task automatic test_relatch();
    logic [15:0] word;
    pad_if.buttons = 12'h0F0;
    host_latch(6, 6);
    for (int i = 0; i < 5; i++) begin
      pad_if.snes_clock = 1'b0;
      tick(6);
      pad_if.snes_clock = 1'b1;
      tick(6);
    end
    pad_if.buttons = 12'h003;
    host_latch(6, 6);
    checks++;
    if (pad_if.snes_data !== 1'b0 || pad_if.busy !== 1'b1 || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL relatch_restart: got data=%b busy=%b fc=%0d required data=0 busy=1 fc=%0d",
               pad_if.snes_data, pad_if.busy, pad_if.frame_count, exp_fc);
    end
    host_frame(6, word);
    exp_fc = exp_fc + 1;
    checks++;
    if (word !== 16'hFFFC || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL relatch_stream: got %h fc=%0d required %h fc=%0d", word, pad_if.frame_count, 16'hFFFC, exp_fc);
    end
  endtask

  task automatic test_button_change();
    logic [15:0] word;
    pad_if.buttons = 12'h000;
    host_latch(6, 6);
    pad_if.buttons = 12'hFFF;
    host_frame(6, word);
    exp_fc = exp_fc + 1;
    checks++;
    if (word !== 16'hFFFF) begin
      errors++;
      $display("FAIL button_change_stream: got %h required %h", word, 16'hFFFF);
    end
  endtask

  task automatic test_reset_midframe();
    pad_if.buttons = 12'h000;
    host_latch(6, 6);
    for (int i = 0; i < 5; i++) begin
      pad_if.snes_clock = 1'b0;
      tick(6);
      pad_if.snes_clock = 1'b1;
      tick(6);
    end
    pad_if.snes_clock = 1'b0;
    tick(6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b0 || pad_if.frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_midframe: got data=%b busy=%b fc=%0d required data=1 busy=0 fc=0",
               pad_if.snes_data, pad_if.busy, pad_if.frame_count);
    end
    pad_if.snes_clock = 1'b1;
    tick(2);
    rst_n = 1'b1;
    exp_fc = 0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      pad_if.snes_clock = 1'b0;
      tick(6);
      pad_if.snes_clock = 1'b1;
      tick(6);
    end
    checks++;
    if (pad_if.snes_data !== 1'b1 || pad_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume: got data=%b busy=%b required data=1 busy=0", pad_if.snes_data, pad_if.busy);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] word;
    pulse_reset();
    pad_if.buttons = 12'hA5A;
    for (int f = 0; f < 300; f++) begin
      host_latch(5, 6);
      host_frame(5, word);
      exp_fc = (exp_fc + 1) % 256;
      if (f == 0 || f == 299) begin
        checks++;
        if (word !== 16'hF5A5) begin
          errors++;
          $display("FAIL wrap_stream[%0d]: got %h required %h", f, word, 16'hF5A5);
        end
      end
      if (f == 255) begin
        checks++;
        if (pad_if.frame_count !== 8'd0) begin
          errors++;
          $display("FAIL wrap_zero: got fc=%0d required 0", pad_if.frame_count);
        end
      end
    end
    checks++;
    if (pad_if.frame_count !== 8'd44 || pad_if.frame_count !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL wrap_count: got fc=%0d required 44", pad_if.frame_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_fc = 0;
    rst_n = 1'b0;
    pad_if.buttons = 12'h000;
    pad_if.snes_latch = 1'b0;
    pad_if.snes_clock = 1'b1;
    tick(2);
    test_reset();
    test_full_frame();
    test_glitch();
    test_coincident();
    test_relatch();
    test_button_change();
    test_reset_midframe();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Device end of the SNES controller serial protocol; emulates a standard 12-button SNES pad toward any host that drives latch/clock and samples data.
- Bench loopback partner for snes_controller, and lets the gameboy top export its own pad state to an external SNES-protocol host over GPIO.
- Host latch/clock are asynchronous to the local clock: synchronised, edge-detected, then shifted out as an active-low serial stream.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for snes_latch and snes_clock (minimum 2).
- NUM_BITS, 16: bits per frame; buttons occupy bits 0..11, bits 12..NUM_BITS-1 are fixed "released".
- MIN_LATCH, 2: consecutive synchronised-high local cycles required to accept a latch (glitch filter).

Ports:
- clock  in  1  local clock (cpu_clock domain, ~4 MHz).
- rst  in  1  asynchronous, active-low reset.
- buttons  in  12  pad state, active-high pressed; order B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R (bit 0 = B).
- snes_latch  in  1  host latch, active-high, asynchronous.
- snes_clock  in  1  host serial clock, idles high, asynchronous.
- snes_data  out  1  serial data to host, active-low (0 = pressed), registered.
- busy  out  1  high from accepted latch until frame complete or next latch.
- frame_count  out  8  number of fully shifted frames, wraps 255->0 (debug / hex display).

Behaviour:
- Reset (rst=0): snes_data=1, busy=0, frame_count=0, state IDLE, bit counter 0, shift register all 1s, synchroniser flops 0 (latch) / 1 (clock).
- Synchronisation: SYNC_STAGES flops per input, plus one history flop; rise/fall decoded from last two stages only.
- States: IDLE, LATCH, SHIFT, DONE.
- IDLE: snes_data=1; clock edges ignored. Latch synchronised high for MIN_LATCH consecutive cycles -> LATCH.
- LATCH: shift register reloaded every cycle with {ones(NUM_BITS-12), ~buttons}; snes_data = ~buttons[0] (live); busy=1; counter=0. Latch falling edge -> SHIFT, holding the last captured word.
- SHIFT: each synchronised snes_clock rising edge shifts right by one, counter+1, snes_data <= next bit, registered one cycle after the detected edge. Host samples data while snes_clock is low; data is stable from rise to next fall.
- Counter reaching NUM_BITS -> DONE; frame_count+1 on the same cycle.
- DONE: snes_data=0 (standard pad drives low after the frame); further clock edges ignored; busy=0.
- Latch accepted in any state (SHIFT, DONE, IDLE) -> LATCH, aborting any frame in progress; the aborted frame is not counted.
- Simultaneous latch-high and clock rising edge: latch wins, no shift.
- Latch high for fewer than MIN_LATCH cycles: ignored in IDLE/DONE. In SHIFT it aborts nothing; the shift proceeds.
- Latency: host latch rise to snes_data valid = SYNC_STAGES+MIN_LATCH cycles. Host clock rise to data change = SYNC_STAGES+1 cycles. Host half-period must exceed SYNC_STAGES+2 local cycles.
- buttons sampled only while in LATCH; changes during SHIFT do not affect the current frame.
- Async reset mid-frame: all outputs return to reset values immediately; the next frame starts only on a new accepted latch.

Decomposition:
- Shared package snes_pkg: button bit index constants (BTN_B=0 .. BTN_R=11), SNES_FRAME_BITS=16, state encoding localparams.
- One natural sub-module: snes_sync_edge (N-stage synchroniser + rise/fall pulse outputs), instantiated twice; snes_controller can reuse it.

Test Plan:
- Reset: rst=0 with latch/clock toggling -> snes_data=1, busy=0, frame_count=0 throughout.
- Full frame, buttons=12'h001 (B only): latch 12 µs, 16 clocks -> sampled stream 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; snes_data=0 after 16th edge; frame_count=1.
- buttons=12'hA5A, loopback with snes_controller -> its snes_buttons[11:0]=~12'hA5A, [15:12]=4'hF; 300 consecutive frames -> frame_count wraps to 44.
- Re-latch after 5 clocks -> restarts at bit 0 with the new buttons; frame_count unchanged by the aborted frame.
- 1-cycle latch glitch in IDLE -> no state change, busy=0. Latch coincident with a clock rise -> no shift, first bit = ~buttons[0].
- buttons changed from 12'h000 to 12'hFFF after latch falls -> the frame still shifts all 1s for bits 0..11.
